// File: rtl/barrel_shifter_pipe_if.sv
// Valid/ready streaming bundle for barrel_shifter_pipe: operand side (in_*) and result side (out_*).
// The slave modport is the shifter's view; master is the producer/consumer view.
interface barrel_shifter_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sticky;

  modport master (
    output in_valid, in_data, in_amt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sticky
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_sticky
  );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined log-stage barrel shifter (SLL/SRL/SRA/ROL), one register stage per shift-amount bit.
// Optional macro BSHIFT_STICKY_EN adds a per-stage sticky bit (OR of all discarded bits).
module barrel_shifter_pipe #(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  barrel_shifter_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0]       MODE_SLL = 2'b00;
  localparam logic [1:0]       MODE_SRL = 2'b01;
  localparam logic [1:0]       MODE_SRA = 2'b10;
  localparam logic [WIDTH-1:0] ONES     = {WIDTH{1'b1}};

  // Stage k register set. a_q holds the not-yet-applied amount bits, LSB next.
  logic             v_q  [SHW];
  logic [WIDTH-1:0] d_q  [SHW];
  logic [SHW-1:0]   a_q  [SHW];
  logic [1:0]       m_q  [SHW];
  logic             sg_q [SHW];

  logic             v_nx  [SHW];
  logic [WIDTH-1:0] d_nx  [SHW];
  logic [SHW-1:0]   a_nx  [SHW];
  logic [1:0]       m_nx  [SHW];
  logic             sg_nx [SHW];

`ifdef BSHIFT_STICKY_EN
  logic             st_q  [SHW];
  logic             st_nx [SHW];
`endif

  logic advance;

  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       m,
                                                   input logic             sg,
                                                   input int               s);
    case (m)
      MODE_SLL: return d << s;
      MODE_SRL: return d >> s;
      MODE_SRA: return (d >> s) | (sg ? ~(ONES >> s) : '0);
      default:  return (d << s) | (d >> (WIDTH - s));
    endcase
  endfunction

`ifdef BSHIFT_STICKY_EN
  function automatic logic stage_lost(input logic [WIDTH-1:0] d,
                                      input logic [1:0]       m,
                                      input int               s);
    case (m)
      MODE_SLL: return |(d >> (WIDTH - s));
      MODE_SRL: return |(d << (WIDTH - s));
      MODE_SRA: return |(d << (WIDTH - s));
      default:  return 1'b0;
    endcase
  endfunction
`endif

  // One global advance: a full output that is not being taken freezes every stage.
  assign advance      = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = advance;

  always_comb begin
    logic             cur_v;
    logic [WIDTH-1:0] cur_d;
    logic [SHW-1:0]   cur_a;
    logic [1:0]       cur_m;
    logic             cur_sg;
`ifdef BSHIFT_STICKY_EN
    logic             cur_st;
    cur_st = 1'b0;
`endif
    cur_v  = bus.in_valid;
    cur_d  = bus.in_data;
    cur_a  = bus.in_amt;
    cur_m  = bus.in_mode;
    cur_sg = bus.in_data[WIDTH-1];
    for (int k = 0; k < SHW; k++) begin
      v_nx[k]  = cur_v;
      d_nx[k]  = cur_a[0] ? stage_shift(cur_d, cur_m, cur_sg, 1 << k) : cur_d;
      a_nx[k]  = cur_a >> 1;
      m_nx[k]  = cur_m;
      sg_nx[k] = cur_sg;
`ifdef BSHIFT_STICKY_EN
      st_nx[k] = cur_st | (cur_a[0] & stage_lost(cur_d, cur_m, 1 << k));
      cur_st   = st_q[k];
`endif
      cur_v  = v_q[k];
      cur_d  = d_q[k];
      cur_a  = a_q[k];
      cur_m  = m_q[k];
      cur_sg = sg_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        v_q[k]  <= 1'b0;
        d_q[k]  <= '0;
        a_q[k]  <= '0;
        m_q[k]  <= '0;
        sg_q[k] <= 1'b0;
      end
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) begin
        v_q[k]  <= v_nx[k];
        d_q[k]  <= d_nx[k];
        a_q[k]  <= a_nx[k];
        m_q[k]  <= m_nx[k];
        sg_q[k] <= sg_nx[k];
      end
    end
  end

`ifdef BSHIFT_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SHW; k++) st_q[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < SHW; k++) st_q[k] <= st_nx[k];
    end
  end

  assign bus.out_sticky = st_q[SHW-1];
`else
  assign bus.out_sticky = 1'b0;
`endif

  assign bus.out_valid = v_q[SHW-1];
  assign bus.out_data  = d_q[SHW-1];
endmodule
